// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned MULTU/DIVU unit that borrows the shared ALU one step per grant.
// Optional abort input enabled by defining MULDIV_ABORT_EN.
module alu_muldiv_seq #(
  parameter int          WIDTH     = 32,
  parameter logic [3:0]  CTRL_ADDU = 4'd4,
  parameter logic [3:0]  CTRL_SUBU = 4'd5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
`ifdef MULDIV_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o,
  output logic             alu_req_o,
  input  logic             alu_gnt_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  input  logic [WIDTH-1:0] alu_result_i
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] rem_p;
  logic             ge, carry;

  // Divide step works on the remainder shifted left by one, pulling in the next dividend bit.
  assign rem_p = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign ge    = hi_q[WIDTH-1] | !(rem_p < d_q);
  assign carry = alu_result_i < hi_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      d_q     <= d_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    d_d        = d_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    dz_d       = dz_q;
    alu_ctrl_o = CTRL_ADDU;
    alu_src1_o = '0;
    alu_src2_o = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          cnt_d = '0;
          dz_d  = 1'b0;
          if (op_i && (src2_i == '0)) begin
            hi_d    = src1_i;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            d_d     = op_i ? src2_i : src1_i;
            hi_d    = '0;
            lo_d    = op_i ? src1_i : src2_i;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (op_q) begin
          alu_ctrl_o = CTRL_SUBU;
          alu_src1_o = rem_p;
          alu_src2_o = d_q;
        end else begin
          alu_src1_o = hi_q;
          alu_src2_o = lo_q[0] ? d_q : '0;
        end
`ifdef MULDIV_ABORT_EN
        if (abort_i) begin
          hi_d    = '0;
          lo_d    = '0;
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end else
`endif
        if (alu_gnt_i) begin
          if (op_q) begin
            hi_d = ge ? alu_result_i : rem_p;
            lo_d = {lo_q[WIDTH-2:0], ge};
          end else begin
            hi_d = {carry, alu_result_i[WIDTH-1:1]};
            lo_d = {alu_result_i[0], lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q == S_RUN);
  assign alu_req_o  = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign div_zero_o = dz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq against a plain-arithmetic reference.
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, op;
  logic [31:0] src1, src2;
  logic        busy, done, dz, req, gnt;
  logic [31:0] hi, lo;
  logic [3:0]  ctrl;
  logic [31:0] asrc1, asrc2, ares;
`ifdef MULDIV_ABORT_EN
  logic        abort;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: 4 = ADDU, 5 = SUBU
  assign ares = (ctrl == 4'd5) ? asrc1 - asrc2 : asrc1 + asrc2;

  alu_muldiv_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .src1_i(src1), .src2_i(src2),
`ifdef MULDIV_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo), .div_zero_o(dz),
    .alu_req_o(req), .alu_gnt_i(gnt), .alu_ctrl_o(ctrl),
    .alu_src1_o(asrc1), .alu_src2_o(asrc2), .alu_result_i(ares)
  );

  function automatic void ref_model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el, output logic ez);
    logic [63:0] p;
    if (!o) begin
      p  = {32'd0, a} * {32'd0, b};
      eh = p[63:32]; el = p[31:0]; ez = 1'b0;
    end else if (b == 0) begin
      eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
    end else begin
      eh = a % b; el = a / b; ez = 1'b0;
    end
  endfunction

  // gmode: 0 = grant always, 1 = alternate 1/0, 2 = random
  task automatic run_op(input string nm, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int gmode);
    logic [31:0] eh, el;
    logic        ez, g, seen_req, seen_done;
    int          idx, stalls, steps, exp_lat;
    ref_model(o, a, b, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b; gnt = 1'b1;
    @(negedge clk);
    start = 1'b0; src1 = $urandom; src2 = $urandom;
    idx = 0; stalls = 0; steps = 0; seen_req = 1'b0; seen_done = 1'b0;
    while (idx < 400) begin
      if (done) begin seen_done = 1'b1; break; end
      if (req) seen_req = 1'b1;
      case (gmode)
        0:       g = 1'b1;
        1:       g = (idx % 2 == 0);
        default: g = ($urandom_range(0, 3) != 0);
      endcase
      gnt = g;
      if (busy) begin
        if (g) steps++; else stalls++;
      end
      @(negedge clk);
      idx++;
    end
    gnt = 1'b1;
    // Zero-divisor completes straight from the start edge; otherwise 32 granted steps plus stalls.
    exp_lat = (o && b == 0) ? 0 : 32 + stalls;
    checks++; if (!seen_done) begin errors++; $display("FAIL %s done_timeout idx=%0d", nm, idx); end
    checks++; if (idx !== exp_lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", nm, idx, exp_lat); end
    checks++; if (hi !== eh) begin errors++; $display("FAIL %s hi got=%h exp=%h", nm, hi, eh); end
    checks++; if (lo !== el) begin errors++; $display("FAIL %s lo got=%h exp=%h", nm, lo, el); end
    checks++; if (dz !== ez) begin errors++; $display("FAIL %s div_zero got=%b exp=%b", nm, dz, ez); end
    if (o && b == 0) begin
      checks++; if (seen_req) begin errors++; $display("FAIL %s alu_req got=1 exp=0", nm); end
    end else begin
      checks++; if (steps !== 32) begin errors++; $display("FAIL %s steps got=%0d exp=32", nm, steps); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== eh || lo !== el || dz !== ez) begin
      errors++; $display("FAIL %s post_done done=%b busy=%b hi=%h lo=%h exp hi=%h lo=%h", nm, done, busy, hi, lo, eh, el);
    end
    checks++;
    if (asrc1 !== 32'd0 || asrc2 !== 32'd0 || ctrl !== 4'd4) begin
      errors++; $display("FAIL %s idle_alu src1=%h src2=%h ctrl=%0d exp 0/0/4", nm, asrc1, asrc2, ctrl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({busy, done, dz, req} !== 4'b0 || hi !== 0 || lo !== 0 || asrc1 !== 0 || asrc2 !== 0 || ctrl !== 4'd4) begin
      errors++; $display("FAIL reset busy=%b done=%b dz=%b req=%b hi=%h lo=%h ctrl=%0d exp all 0 ctrl=4",
                         busy, done, dz, req, hi, lo, ctrl);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 0);
    run_op("div_zero", 1'b1, 32'h1234, 32'd0, 0);
    run_op("mul_toggle", 1'b0, 32'd12345, 32'd6789, 1);
    run_op("div_by_one", 1'b1, 32'hDEAD_BEEF, 32'd1, 2);
    run_op("div_big", 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 2);
    run_op("mul_zero", 1'b0, 32'd0, 32'hABCD_0123, 2);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 6 == 5) ? 32'd0 : ($urandom_range(0, 1) != 0 ? $urandom : 32'($urandom_range(1, 300)));
      run_op("random", 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
    end
  endtask

  task automatic test_start_ignored_reset();
    @(negedge clk);
    start = 1'b1; op = 1'b0; src1 = 32'd99; src2 = 32'd77; gnt = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 1'b1; src1 = 32'd5; src2 = 32'd0;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ctrl !== 4'd4) begin
      errors++; $display("FAIL start_ignored busy=%b ctrl=%0d exp 1/4", busy, ctrl);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL async_req_drop got=%b exp=0", req); end
    @(negedge clk);
    checks++;
    if ({busy, done, dz, req} !== 4'b0 || hi !== 0 || lo !== 0) begin
      errors++; $display("FAIL midrun_reset busy=%b done=%b dz=%b req=%b hi=%h lo=%h exp 0", busy, done, dz, req, hi, lo);
    end
    rst = 1'b0;
    run_op("div_7_100", 1'b1, 32'd7, 32'd100, 0);
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic test_abort();
    bit pulsed = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; src1 = 32'hFFFF_0000; src2 = 32'h1234_5678; gnt = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1; gnt = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 0 || lo !== 0 || dz !== 1'b0) begin
      errors++; $display("FAIL abort busy=%b hi=%h lo=%h dz=%b exp 0", busy, hi, lo, dz);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) pulsed = 1'b1;
      @(negedge clk);
    end
    checks++; if (pulsed) begin errors++; $display("FAIL abort_done got=1 exp=0"); end
  endtask
`endif

  initial begin
    start = 1'b0; op = 1'b0; src1 = '0; src2 = '0; gnt = 1'b1;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_start_ignored_reset();
`ifdef MULDIV_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
